// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/hazard/regfile to decode bundle for the IF/ID stage
interface if_id_stage_if;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        StallD;
  logic        FlushD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ALUOutM;
  logic        ForwardAD;
  logic        ForwardBD;

  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  RdD;
  logic [31:0] SignImmD;
  logic        BranchD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        Jump;
  logic [27:0] PCJ;

  modport master (
    output InstrF, PCPlus4F, StallD, FlushD, RD1D, RD2D, ALUOutM, ForwardAD, ForwardBD,
    input  InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SignImmD, BranchD,
           PCSrcD, PCBranchD, Jump, PCJ
  );

  modport slave (
    input  InstrF, PCPlus4F, StallD, FlushD, RD1D, RD2D, ALUOutM, ForwardAD, ForwardBD,
    output InstrD, PCPlus4D, ValidD, RsD, RtD, RdD, SignImmD, BranchD,
           PCSrcD, PCBranchD, Jump, PCJ
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with decode-side branch/jump resolution
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input logic         CLK,
  input logic         reset,
  if_id_stage_if.slave bus
);

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  logic [5:0]  opcode;
  logic        is_beq;
  logic        is_bne;
  logic        is_branch;
  logic        is_jump;
  logic [31:0] sign_imm;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        operands_eq;
  logic        branch_taken;
  logic        redirect;

  assign opcode    = instr_q[31:26];
  // A bubble must never redirect fetch, whatever bits it happens to carry.
  assign is_beq    = valid_q && (opcode == OP_BEQ);
  assign is_bne    = valid_q && (opcode == OP_BNE);
  assign is_branch = is_beq || is_bne;
  assign is_jump   = valid_q && ((opcode == OP_J) || (opcode == OP_JAL));

  assign sign_imm  = {{16{instr_q[15]}}, instr_q[15:0]};

  assign cmp_a       = bus.ForwardAD ? bus.ALUOutM : bus.RD1D;
  assign cmp_b       = bus.ForwardBD ? bus.ALUOutM : bus.RD2D;
  assign operands_eq = (cmp_a == cmp_b);

  assign branch_taken = (is_beq && operands_eq) || (is_bne && !operands_eq);
  assign redirect     = branch_taken || is_jump;

  // Stall outranks every squash source so a held branch keeps its redirect asserted.
  always_ff @(posedge CLK) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC4;
      valid_q <= 1'b0;
    end else if (!bus.StallD) begin
      if (bus.FlushD || redirect) begin
        instr_q <= NOP_INSTR;
        pc4_q   <= RESET_PC4;
        valid_q <= 1'b0;
      end else begin
        instr_q <= bus.InstrF;
        pc4_q   <= bus.PCPlus4F;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.InstrD    = instr_q;
  assign bus.PCPlus4D  = pc4_q;
  assign bus.ValidD    = valid_q;
  assign bus.RsD       = instr_q[25:21];
  assign bus.RtD       = instr_q[20:16];
  assign bus.RdD       = instr_q[15:11];
  assign bus.SignImmD  = sign_imm;
  assign bus.BranchD   = is_branch;
  assign bus.PCSrcD    = branch_taken;
  assign bus.PCBranchD = pc4_q + {sign_imm[29:0], 2'b00};
  assign bus.Jump      = is_jump;
  assign bus.PCJ       = {instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized self-checking bench for if_id_stage against a behavioural model
module tb_if_id_stage;

  logic CLK;
  logic reset;
  int   checks;
  int   errors;

  if_id_stage_if bus ();

  if_id_stage dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model of the pipeline register contents
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit model_taken(input logic [31:0] instr, input logic valid);
    int unsigned op;
    logic [31:0] a, b;
    op = instr >> 26;
    a  = bus.ForwardAD ? bus.ALUOutM : bus.RD1D;
    b  = bus.ForwardBD ? bus.ALUOutM : bus.RD2D;
    if (!valid) return 0;
    if (op == 4) return a == b;
    if (op == 5) return a != b;
    return 0;
  endfunction

  function automatic bit model_jump(input logic [31:0] instr, input logic valid);
    int unsigned op;
    op = instr >> 26;
    return valid && (op == 2 || op == 3);
  endfunction

  task automatic check_model();
    int unsigned op;
    int          off;
    logic [31:0] target;
    logic [31:0] imm;
    logic [27:0] pcj;
    op     = m_instr >> 26;
    off    = int'($signed(m_instr[15:0]));
    imm    = 32'(off);
    target = 32'(m_pc4 + 32'(off * 4));
    pcj    = 28'((m_instr & 32'h03FF_FFFF) * 4);
    chk("InstrD",    bus.InstrD,    m_instr);
    chk("PCPlus4D",  bus.PCPlus4D,  m_pc4);
    chk("ValidD",    32'(bus.ValidD), 32'(m_valid));
    chk("RsD",       32'(bus.RsD),  (m_instr >> 21) % 32);
    chk("RtD",       32'(bus.RtD),  (m_instr >> 16) % 32);
    chk("RdD",       32'(bus.RdD),  (m_instr >> 11) % 32);
    chk("SignImmD",  bus.SignImmD,  imm);
    chk("BranchD",   32'(bus.BranchD), 32'(m_valid && (op == 4 || op == 5)));
    chk("PCSrcD",    32'(bus.PCSrcD), 32'(model_taken(m_instr, m_valid)));
    chk("PCBranchD", bus.PCBranchD, target);
    chk("Jump",      32'(bus.Jump), 32'(model_jump(m_instr, m_valid)));
    chk("PCJ",       32'(bus.PCJ),  32'(pcj));
  endtask

  task automatic tick();
    logic [31:0] n_instr, n_pc4;
    logic        n_valid;
    bit          bubble;
    bubble = reset || (!bus.StallD && (bus.FlushD || model_taken(m_instr, m_valid)
                                       || model_jump(m_instr, m_valid)));
    if (bubble) begin
      n_instr = 32'h0; n_pc4 = 32'h4; n_valid = 1'b0;
    end else if (bus.StallD) begin
      n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    end else begin
      n_instr = bus.InstrF; n_pc4 = bus.PCPlus4F; n_valid = 1'b1;
    end
    @(posedge CLK);
    #1;
    m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned pick;
    w    = $urandom;
    pick = $urandom_range(0, 6);
    case (pick)
      0: w[31:26] = 6'h00;
      1: w[31:26] = 6'h02;
      2: w[31:26] = 6'h03;
      3, 4: w[31:26] = 6'h04;
      5: w[31:26] = 6'h05;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    m_instr = 32'h0; m_pc4 = 32'h4; m_valid = 1'b0;
    reset = 1'b1;
    bus.InstrF = 32'h2008_0005; bus.PCPlus4F = 32'h4;
    bus.StallD = 0; bus.FlushD = 0;
    bus.RD1D = 0; bus.RD2D = 0; bus.ALUOutM = 0;
    bus.ForwardAD = 0; bus.ForwardBD = 0;

    // Reset
    tick(); tick();
    chk("rst_valid", 32'(bus.ValidD), 32'd0);
    chk("rst_instr", bus.InstrD, 32'h0);
    chk("rst_pcsrc", 32'(bus.PCSrcD), 32'd0);
    chk("rst_jump",  32'(bus.Jump), 32'd0);
    chk("rst_pcbr",  bus.PCBranchD, 32'h4);
    reset = 1'b0;
    tick();
    chk("rel_instr", bus.InstrD, 32'h2008_0005);
    chk("rel_valid", 32'(bus.ValidD), 32'd1);
    chk("rel_pc4",   bus.PCPlus4D, 32'h4);

    // Taken beq, then wrong-path squash
    bus.InstrF = 32'h1085_0003; bus.PCPlus4F = 32'h40; bus.RD1D = 7; bus.RD2D = 7;
    tick();
    chk("beq_pcsrc", 32'(bus.PCSrcD), 32'd1);
    chk("beq_pcbr",  bus.PCBranchD, 32'h4C);
    bus.InstrF = 32'hDEAD_BEEF;
    tick();
    chk("beq_bubble", 32'(bus.ValidD), 32'd0);

    // bne not taken, then forwarded operand makes it taken
    bus.InstrF = 32'h1485_FFFF; bus.PCPlus4F = 32'h100; bus.RD1D = 9; bus.RD2D = 9;
    tick();
    chk("bne_nt", 32'(bus.PCSrcD), 32'd0);
    bus.ForwardAD = 1; bus.ALUOutM = 10;
    #1;
    check_model();
    chk("bne_fwd_pcsrc", 32'(bus.PCSrcD), 32'd1);
    chk("bne_fwd_pcbr",  bus.PCBranchD, 32'hFC);

    // Jump: the taken bne squashes first, then j loads
    bus.InstrF = 32'h0800_0010; bus.PCPlus4F = 32'h200;
    tick();
    bus.ForwardAD = 0;
    tick();
    chk("j_jump", 32'(bus.Jump), 32'd1);
    chk("j_pcj",  32'(bus.PCJ), 32'h0000_0040);
    bus.InstrF = 32'h0;
    tick();
    chk("j_bubble", 32'(bus.ValidD), 32'd0);

    // Stall outranks flush and a taken branch
    bus.InstrF = 32'h1085_0003; bus.PCPlus4F = 32'h40; bus.RD1D = 7; bus.RD2D = 7;
    tick();
    bus.StallD = 1; bus.FlushD = 1; bus.InstrF = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_instr", bus.InstrD, 32'h1085_0003);
      chk("stl_pc4",   bus.PCPlus4D, 32'h40);
      chk("stl_valid", 32'(bus.ValidD), 32'd1);
      chk("stl_pcsrc", 32'(bus.PCSrcD), 32'd1);
    end
    bus.StallD = 0; bus.FlushD = 0;
    tick();
    chk("stl_release", 32'(bus.ValidD), 32'd0);

    // Target wrap-around
    bus.InstrF = 32'h1085_0001; bus.PCPlus4F = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pcbr", bus.PCBranchD, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.InstrF    = rand_instr();
      bus.PCPlus4F  = $urandom & 32'hFFFF_FFFC;
      bus.RD1D      = $urandom_range(0, 3);
      bus.RD2D      = $urandom_range(0, 3);
      bus.ALUOutM   = $urandom_range(0, 3);
      bus.ForwardAD = ($urandom_range(0, 3) == 0);
      bus.ForwardBD = ($urandom_range(0, 3) == 0);
      bus.StallD    = ($urandom_range(0, 4) == 0);
      bus.FlushD    = ($urandom_range(0, 9) == 0);
      reset         = ($urandom_range(0, 39) == 0);
      #1;
      check_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
